// File: rtl/instr_mem_loader.sv
// Byte-stream loader for the instruction memory: writes bytes to consecutive addresses until the HALT word.
// The optional inter-byte timeout is built only when LOADER_TIMEOUT_EN is defined.
module instr_mem_loader #(
   parameter int                   INSTMEM_SIZE   = 8,
   parameter int                   MEM_SIZE       = 8,
   parameter int                   INST_SIZE      = 32,
   parameter logic [INST_SIZE-1:0] HALT_INSTR     = 32'hFFFF_FFFF,
   parameter int                   TIMEOUT_CYCLES = 1_000_000
) (
   input  logic                    i_clock,
   input  logic                    i_reset,
   input  logic                    i_start,
   input  logic                    i_rx_valid,
   input  logic [MEM_SIZE-1:0]     i_rx_data,
   output logic                    o_rx_ready,
   output logic                    o_instrmem_en,
   output logic                    o_write_en,
   output logic [INSTMEM_SIZE-1:0] o_write_addr,
   output logic [MEM_SIZE-1:0]     o_write_data,
   output logic                    o_pc_reset,
   output logic                    o_done,
   output logic                    o_overflow,
   output logic                    o_timeout,
   output logic [INSTMEM_SIZE-2:0] o_instr_count
);

   localparam int BYTES = INST_SIZE / MEM_SIZE;
   localparam int IDX_W = (BYTES > 1) ? $clog2(BYTES) : 1;
   localparam int HIST_W = INST_SIZE - MEM_SIZE;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BYTES - 1);
   localparam logic [INSTMEM_SIZE-1:0] TOP_ADDR = '1;

   typedef enum logic [2:0] {S_IDLE, S_LOAD, S_FLUSH, S_DONE, S_ERROR} state_t;

   state_t                  state, next_state;
   logic [INSTMEM_SIZE-1:0] addr;
   logic [IDX_W-1:0]        byte_idx;
   logic [HIST_W-1:0]       word_hist;
   logic                    flush_err;
   logic                    timeout_hit;

   logic                 accept, restart, word_end, is_halt, at_top;
   logic [INST_SIZE-1:0] completed;

   // o_rx_ready is high exactly in LOAD; a start pulse in the same cycle discards the byte.
   assign accept    = i_rx_valid && o_rx_ready && !i_start;
   assign restart   = i_start && (state != S_FLUSH);
   assign completed = {word_hist, i_rx_data};
   assign word_end  = (byte_idx == LAST_IDX);
   assign is_halt   = word_end && (completed == HALT_INSTR);
   assign at_top    = (addr == TOP_ADDR);

   // NOTE: next_state gets a default before the case so no path leaves it unassigned (no latch).
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:  if (i_start) next_state = S_LOAD;
         S_LOAD: begin
            if (i_start)                           next_state = S_LOAD;
            else if (accept && (is_halt || at_top)) next_state = S_FLUSH;
            else if (timeout_hit)                  next_state = S_ERROR;
         end
         S_FLUSH: next_state = flush_err ? S_ERROR : S_DONE;
         S_DONE, S_ERROR: if (i_start) next_state = S_LOAD;
         default: next_state = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         state         <= S_IDLE;
         addr          <= '0;
         byte_idx      <= '0;
         word_hist     <= '0;
         flush_err     <= 1'b0;
         o_instr_count <= '0;
         o_write_en    <= 1'b0;
         o_write_addr  <= '0;
         o_write_data  <= '0;
         o_rx_ready    <= 1'b0;
         o_instrmem_en <= 1'b0;
         o_pc_reset    <= 1'b1;
         o_done        <= 1'b0;
         o_overflow    <= 1'b0;
      end else begin
         state      <= next_state;
         o_write_en <= accept;
         if (accept) begin
            o_write_addr <= addr;
            o_write_data <= i_rx_data;
         end
         if (restart) begin
            addr          <= '0;
            byte_idx      <= '0;
            word_hist     <= '0;
            o_instr_count <= '0;
         end else if (accept) begin
            addr      <= addr + 1'b1;
            word_hist <= completed[HIST_W-1:0];
            byte_idx  <= word_end ? '0 : byte_idx + 1'b1;
            if (word_end) o_instr_count <= o_instr_count + 1'b1;
         end
         if (state == S_LOAD && next_state == S_FLUSH) flush_err <= !is_halt;
         o_rx_ready    <= (next_state == S_LOAD);
         o_instrmem_en <= (next_state == S_LOAD) || (next_state == S_FLUSH) || (next_state == S_DONE);
         o_pc_reset    <= (next_state != S_DONE);
         o_done        <= (next_state == S_DONE);
         // The error cause is latched on ERROR entry and held until the block leaves ERROR.
         o_overflow    <= (next_state == S_ERROR) &&
                          ((state == S_ERROR) ? o_overflow : (state == S_FLUSH && flush_err));
      end
   end

`ifdef LOADER_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);

   logic [TW-1:0] idle_cnt;

   // idle_cnt counts idle LOAD cycles before the current one; this cycle is idle number idle_cnt+1.
   assign timeout_hit = (state == S_LOAD) && !accept && (idle_cnt == T_LAST);

   always_ff @(posedge i_clock or negedge i_reset) begin
      if (!i_reset) begin
         idle_cnt  <= '0;
         o_timeout <= 1'b0;
      end else begin
         if (restart || accept || state != S_LOAD) idle_cnt <= '0;
         else                                      idle_cnt <= idle_cnt + 1'b1;
         o_timeout <= (next_state == S_ERROR) &&
                      ((state == S_ERROR) ? o_timeout : (state == S_LOAD && timeout_hit));
      end
   end
`else
   logic unused_timeout_cfg;
   assign unused_timeout_cfg = (TIMEOUT_CYCLES == 0);
   assign timeout_hit        = 1'b0;
   assign o_timeout          = 1'b0;
`endif

endmodule

// File: tb/tb_instr_mem_loader.sv
// Self-checking bench for instr_mem_loader (INSTMEM_SIZE=4, TIMEOUT_CYCLES=20); write strobes are
// checked against a scoreboard queue filled as bytes are driven.
module tb_instr_mem_loader;

   localparam int AW = 4;

   logic          i_clock = 1'b0;
   logic          i_reset = 1'b1;
   logic          i_start = 1'b0;
   logic          i_rx_valid = 1'b0;
   logic [7:0]    i_rx_data = '0;
   logic          o_rx_ready, o_instrmem_en, o_write_en, o_pc_reset, o_done, o_overflow, o_timeout;
   logic [AW-1:0] o_write_addr;
   logic [7:0]    o_write_data;
   logic [AW-2:0] o_instr_count;

   typedef struct packed {
      logic [AW-1:0] addr;
      logic [7:0]    data;
   } wr_t;

   wr_t           exp_q[$];
   logic [AW-1:0] exp_addr = '0;
   int            n_cmp = 0;
   int            n_err = 0;

   instr_mem_loader #(.INSTMEM_SIZE(AW), .TIMEOUT_CYCLES(20)) dut (
      .i_clock(i_clock), .i_reset(i_reset), .i_start(i_start),
      .i_rx_valid(i_rx_valid), .i_rx_data(i_rx_data), .o_rx_ready(o_rx_ready),
      .o_instrmem_en(o_instrmem_en), .o_write_en(o_write_en), .o_write_addr(o_write_addr),
      .o_write_data(o_write_data), .o_pc_reset(o_pc_reset), .o_done(o_done),
      .o_overflow(o_overflow), .o_timeout(o_timeout), .o_instr_count(o_instr_count)
   );

   always #5 i_clock = ~i_clock;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got time %0t required < 200000", $time);
      $fatal(1);
   end

   // Scoreboard: every strobe must match the oldest expected write.
   always @(negedge i_clock) begin
      if (o_write_en) begin
         n_cmp++;
         if (exp_q.size() == 0) begin
            n_err++;
            $display("FAIL write: unexpected strobe addr=%0h data=%0h, required no write", o_write_addr, o_write_data);
         end else begin
            wr_t e;
            e = exp_q.pop_front();
            if ({o_write_addr, o_write_data} !== e) begin
               n_err++;
               $display("FAIL write: got addr=%0h data=%0h, required addr=%0h data=%0h",
                        o_write_addr, o_write_data, e.addr, e.data);
            end
         end
      end
   end

   task automatic step();
      @(posedge i_clock);
      #1;
   endtask

   task automatic do_start();
      i_start = 1'b1;
      step();
      i_start = 1'b0;
      exp_addr = '0;
      n_cmp++; if (o_rx_ready !== 1'b1) begin n_err++; $display("FAIL start_ready: got %b required 1", o_rx_ready); end
   endtask

   task automatic send(input logic [7:0] b, input bit exp_acc);
      i_rx_valid = 1'b1;
      i_rx_data  = b;
      n_cmp++;
      if (o_rx_ready !== exp_acc) begin
         n_err++; $display("FAIL rx_ready: byte %0h got %b required %b", b, o_rx_ready, exp_acc);
      end
      if (exp_acc) begin
         exp_q.push_back('{addr: exp_addr, data: b});
         exp_addr++;
      end
      step();
   endtask

   task automatic check_done(input logic [AW-2:0] cnt);
      n_cmp++; if (o_done !== 1'b1) begin n_err++; $display("FAIL done: got %b required 1", o_done); end
      n_cmp++; if (o_pc_reset !== 1'b0) begin n_err++; $display("FAIL pc_reset_done: got %b required 0", o_pc_reset); end
      n_cmp++; if (o_instr_count !== cnt) begin n_err++; $display("FAIL instr_count: got %0d required %0d", o_instr_count, cnt); end
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL missing_writes: got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic send_halt();
      for (int i = 0; i < 4; i++) send(8'hFF, 1'b1);
      i_rx_valid = 1'b0;
      step();
   endtask

   task automatic test_reset();
      #3 i_reset = 1'b0;
      #1;
      n_cmp++; if (o_pc_reset !== 1'b1) begin n_err++; $display("FAIL reset_pc: got %b required 1", o_pc_reset); end
      n_cmp++; if ({o_rx_ready, o_write_en, o_instrmem_en, o_done, o_overflow, o_timeout} !== 6'b0) begin
         n_err++; $display("FAIL reset_flags: got %b required 000000",
                           {o_rx_ready, o_write_en, o_instrmem_en, o_done, o_overflow, o_timeout});
      end
      n_cmp++; if ({o_write_addr, o_write_data, o_instr_count} !== '0) begin
         n_err++; $display("FAIL reset_data: got addr=%0h data=%0h cnt=%0d required 0", o_write_addr, o_write_data, o_instr_count);
      end
      step();
      i_reset = 1'b1;
      step();
      n_cmp++; if (o_rx_ready !== 1'b0) begin n_err++; $display("FAIL idle_ready: got %b required 0", o_rx_ready); end
   endtask

   task automatic test_clean_load();
      logic [7:0] bytes [8];
      bytes = '{8'h00, 8'h11, 8'h22, 8'h33, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
      do_start();
      for (int i = 0; i < 8; i++) send(bytes[i], 1'b1);
      n_cmp++; if (o_rx_ready !== 1'b0 || o_done !== 1'b0) begin
         n_err++; $display("FAIL flush_state: got ready=%b done=%b required 0 0", o_rx_ready, o_done);
      end
      n_cmp++; if (o_instr_count !== 3'd2) begin n_err++; $display("FAIL count_t1: got %0d required 2", o_instr_count); end
      i_rx_valid = 1'b0;
      step();
      check_done(3'd2);
      send(8'h55, 1'b0);
      i_rx_valid = 1'b0;
   endtask

   task automatic test_overflow();
      do_start();
      for (int i = 0; i < 16; i++) send(8'h10 + 8'(i), 1'b1);
      step();
      n_cmp++; if (o_overflow !== 1'b1 || o_pc_reset !== 1'b1 || o_done !== 1'b0) begin
         n_err++; $display("FAIL overflow: got ovf=%b pc=%b done=%b required 1 1 0", o_overflow, o_pc_reset, o_done);
      end
      n_cmp++; if (o_instr_count !== 3'd4) begin n_err++; $display("FAIL ovf_count: got %0d required 4", o_instr_count); end
      send(8'h77, 1'b0);
      i_rx_valid = 1'b0;
      n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL ovf_writes: got %0d pending required 0", exp_q.size()); end
   endtask

   task automatic test_halt_at_top();
      do_start();
      for (int i = 0; i < 12; i++) send(8'h40 + 8'(i), 1'b1);
      send_halt();
      check_done(3'd4);
      n_cmp++; if (o_overflow !== 1'b0) begin n_err++; $display("FAIL top_halt_ovf: got %b required 0", o_overflow); end
   endtask

   task automatic test_restart();
      do_start();
      for (int i = 0; i < 5; i++) send(8'h80 + 8'(i), 1'b1);
      i_start    = 1'b1;
      i_rx_data  = 8'hAA;
      step();
      i_start  = 1'b0;
      exp_addr = '0;
      n_cmp++; if (o_instr_count !== 3'd0 || o_rx_ready !== 1'b1) begin
         n_err++; $display("FAIL restart: got cnt=%0d ready=%b required 0 1", o_instr_count, o_rx_ready);
      end
      for (int i = 0; i < 4; i++) send(8'h01 + 8'(i), 1'b1);
      send_halt();
      check_done(3'd2);
   endtask

   task automatic test_back_to_back_gaps();
      do_start();
      for (int i = 0; i < 8; i++) begin
         send((i < 4) ? 8'hC0 + 8'(i) : 8'hFF, 1'b1);
         i_rx_valid = 1'b0;
         if (i < 7) repeat (3) step();
      end
      step();
      check_done(3'd2);
   endtask

   task automatic test_reset_mid_load();
      do_start();
      send(8'h21, 1'b1);
      send(8'h22, 1'b1);
      n_cmp++; if (o_write_en !== 1'b1) begin n_err++; $display("FAIL pending_strobe: got %b required 1", o_write_en); end
      i_reset = 1'b0;
      #1;
      exp_q.delete();
      n_cmp++; if (o_write_en !== 1'b0 || o_rx_ready !== 1'b0 || o_pc_reset !== 1'b1 || o_instr_count !== 3'd0) begin
         n_err++; $display("FAIL reset_abort: got wen=%b ready=%b pc=%b cnt=%0d required 0 0 1 0",
                           o_write_en, o_rx_ready, o_pc_reset, o_instr_count);
      end
      i_rx_valid = 1'b0;
      i_reset = 1'b1;
      step();
      n_cmp++; if (o_rx_ready !== 1'b0) begin n_err++; $display("FAIL reset_idle: got %b required 0", o_rx_ready); end
      do_start();
      for (int i = 0; i < 4; i++) send(8'h31 + 8'(i), 1'b1);
      send_halt();
      check_done(3'd2);
   endtask

   task automatic test_stall();
      do_start();
      for (int i = 0; i < 3; i++) send(8'hD0 + 8'(i), 1'b1);
      i_rx_valid = 1'b0;
`ifdef LOADER_TIMEOUT_EN
      repeat (19) step();
      n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_early: got %b required 0", o_timeout); end
      step();
      n_cmp++; if (o_timeout !== 1'b1 || o_pc_reset !== 1'b1 || o_rx_ready !== 1'b0) begin
         n_err++; $display("FAIL timeout: got to=%b pc=%b ready=%b required 1 1 0", o_timeout, o_pc_reset, o_rx_ready);
      end
      do_start();
      n_cmp++; if (o_timeout !== 1'b0) begin n_err++; $display("FAIL timeout_clear: got %b required 0", o_timeout); end
      send_halt();
      check_done(3'd1);
`else
      repeat (40) step();
      n_cmp++; if (o_timeout !== 1'b0 || o_rx_ready !== 1'b1) begin
         n_err++; $display("FAIL stall_wait: got to=%b ready=%b required 0 1", o_timeout, o_rx_ready);
      end
      send(8'hD3, 1'b1);
      send_halt();
      check_done(3'd2);
`endif
   endtask

   initial begin
      test_reset();
      test_clean_load();
      test_overflow();
      test_halt_at_top();
      test_restart();
      test_back_to_back_gaps();
      test_reset_mid_load();
      test_stall();
      repeat (2) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
